// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// sequence lengths and the ID-stage csr/return opcode codes.
package hazard_pkg;

    localparam int unsigned REG_W        = 5;
    localparam int unsigned CNT_W        = 2;
    localparam int unsigned OP_W         = 2;
    localparam int unsigned DRAIN_CYCLES = 3;
    localparam int unsigned FLUSH_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ISSUE = 2'd2,
        FLUSH = 2'd3
    } hz_state_e;

    localparam logic [OP_W-1:0] CSR_NONE  = 2'b00;
    localparam logic [OP_W-1:0] CSR_RW    = 2'b01;
    localparam logic [OP_W-1:0] CSR_RS    = 2'b10;
    localparam logic [OP_W-1:0] RET_NONE  = 2'b00;
    localparam logic [OP_W-1:0] RET_MRET  = 2'b01;
    localparam logic [OP_W-1:0] RET_SRET  = 2'b10;

    // CSR accesses and privilege returns must see a quiet pipeline before issuing.
    function automatic logic is_serialize(input logic [OP_W-1:0] csr_op,
                                          input logic [OP_W-1:0] priv_ret);
        return (csr_op != CSR_NONE) || (priv_ret != RET_NONE);
    endfunction

endpackage

// File: rtl/hazard_ctrl_loaduse_det.sv
// Load-use detector: flags an ID instruction that needs the result of a load
// still in EX. A store's rs2 data is forwarded from MEM, so it never stalls.
module loaduse_det
    import hazard_pkg::*;
(
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_mem_write_forward,
    output logic             load_use_c
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = (ex_rd == id_rs1);
    assign rs2_hit    = (ex_rd == id_rs2) && !id_mem_write_forward;
    assign load_use_c = ex_mem_read && (ex_rd != REG_W'(0)) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and the
// drain/issue/flush sequence that serializes CSR and privilege-return ops.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_mem_write_forward,
    input  logic [OP_W-1:0]  id_csr_op,
    input  logic [OP_W-1:0]  id_priv_ret,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_br_taken,
    output logic             ctrl_stall,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             hz_busy
);

    hz_state_e        state;
    hz_state_e        state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             ret_q;
    logic             ret_d;
    logic             load_use_c;
    logic             serialize_c;

    loaduse_det u_loaduse_det (
        .ex_mem_read          (ex_mem_read),
        .ex_rd                (ex_rd),
        .id_rs1               (id_rs1),
        .id_rs2               (id_rs2),
        .id_mem_write_forward (id_mem_write_forward),
        .load_use_c           (load_use_c)
    );

    assign serialize_c = is_serialize(id_csr_op, id_priv_ret);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ret_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            ret_q <= ret_d;
        end
    end

    // Next state and output decode; outputs react to ID/EX in the same cycle.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        ret_d      = ret_q;
        ctrl_stall = 1'b0;
        pc_hold    = 1'b0;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;

        case (state)
            IDLE: begin
                if (ex_br_taken) begin
                    ctrl_stall = 1'b1;
                    ifid_flush = 1'b1;
                end else if (load_use_c) begin
                    ctrl_stall = 1'b1;
                    pc_hold    = 1'b1;
                    ifid_hold  = 1'b1;
                end else if (serialize_c) begin
                    ctrl_stall = 1'b1;
                    pc_hold    = 1'b1;
                    ifid_hold  = 1'b1;
                    cnt_d      = CNT_W'(DRAIN_CYCLES - 1);
                    ret_d      = (id_priv_ret != RET_NONE);
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                // An older taken branch squashes the waiting instruction.
                if (ex_br_taken) begin
                    ctrl_stall = 1'b1;
                    ifid_flush = 1'b1;
                    cnt_d      = '0;
                    ret_d      = 1'b0;
                    state_d    = IDLE;
                end else begin
                    ctrl_stall = 1'b1;
                    pc_hold    = 1'b1;
                    ifid_hold  = 1'b1;
                    if (cnt == '0) begin
                        state_d = ISSUE;
                    end else begin
                        cnt_d = cnt - CNT_W'(1);
                    end
                end
            end
            ISSUE: begin
                ret_d = 1'b0;
                if (ret_q) begin
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    state_d = FLUSH;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                ctrl_stall = 1'b1;
                ifid_flush = 1'b1;
                if (cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                ret_d   = 1'b0;
            end
        endcase

        if (rst) begin
            ctrl_stall = 1'b1;
            ifid_flush = 1'b1;
            pc_hold    = 1'b0;
            ifid_hold  = 1'b0;
        end
    end

    assign hz_busy = (state != IDLE) && !rst;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle expected output vectors are
// queued as stimulus is applied and compared when outputs settle.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic             id_mem_write_forward, ex_mem_read, ex_br_taken;
    logic [OP_W-1:0]  id_csr_op, id_priv_ret;
    logic             ctrl_stall, pc_hold, ifid_hold, ifid_flush, hz_busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] exp;
        string      name;
    } sb_t;
    sb_t sb_q[$];

    hazard_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .id_rs1               (id_rs1),
        .id_rs2               (id_rs2),
        .id_mem_write_forward (id_mem_write_forward),
        .id_csr_op            (id_csr_op),
        .id_priv_ret          (id_priv_ret),
        .ex_mem_read          (ex_mem_read),
        .ex_rd                (ex_rd),
        .ex_br_taken          (ex_br_taken),
        .ctrl_stall           (ctrl_stall),
        .pc_hold              (pc_hold),
        .ifid_hold            (ifid_hold),
        .ifid_flush           (ifid_flush),
        .hz_busy              (hz_busy)
    );

    always #5 clk = ~clk;

    // Output vector order: {ctrl_stall, pc_hold, ifid_hold, ifid_flush, hz_busy}
    function automatic logic [4:0] obs();
        return {ctrl_stall, pc_hold, ifid_hold, ifid_flush, hz_busy};
    endfunction

    // Hold and flush of IF/ID must be mutually exclusive every cycle.
    always @(negedge clk) begin
        total++;
        if ((ifid_hold & ifid_flush) !== 1'b0) begin
            bad++;
            $display("FAIL hold_flush_excl: ifid_hold=%b ifid_flush=%b at %0t", ifid_hold, ifid_flush, $time);
        end
    end

    task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic swf, input logic [1:0] csr, input logic [1:0] ret,
                         input logic mr, input logic [4:0] rd, input logic br,
                         input logic [4:0] exp, input string nm);
        @(posedge clk);
        #1;
        rst = r; id_rs1 = rs1; id_rs2 = rs2; id_mem_write_forward = swf;
        id_csr_op = csr; id_priv_ret = ret; ex_mem_read = mr; ex_rd = rd; ex_br_taken = br;
        sb_q.push_back('{exp: exp, name: nm});
    endtask

    task automatic test_reset();
        sb_t e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'd0, 5'd0, 1'b0, CSR_NONE, RET_NONE, 1'b0, 5'd0, 1'b0, 5'b10010, "reset_out");
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (obs() !== e.exp) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
            end
        end
        total++;
        if (dut.cnt !== 2'd0 || dut.ret_q !== 1'b0) begin
            bad++;
            $display("FAIL reset_regs: cnt=%0d ret_q=%b want 0 0", dut.cnt, dut.ret_q);
        end
    endtask

    task automatic test_load_use();
        sb_t e;
        // Matching rs1 stalls once; next cycle EX holds the bubble.
        drive(1'b0, 5'd5, 5'd0, 1'b0, CSR_NONE, RET_NONE, 1'b1, 5'd5, 1'b0, 5'b11100, "lu_rs1");
        drive(1'b0, 5'd5, 5'd0, 1'b0, CSR_NONE, RET_NONE, 1'b0, 5'd0, 1'b0, 5'b00000, "lu_after");
        // Non-store rs2 dependency also stalls.
        drive(1'b0, 5'd3, 5'd9, 1'b0, CSR_NONE, RET_NONE, 1'b1, 5'd9, 1'b0, 5'b11100, "lu_rs2");
        drive(1'b0, 5'd3, 5'd7, 1'b1, CSR_NONE, RET_NONE, 1'b1, 5'd7, 1'b0, 5'b00000, "store_rs2_fwd");
        drive(1'b0, 5'd0, 5'd7, 1'b1, CSR_NONE, RET_NONE, 1'b1, 5'd0, 1'b0, 5'b00000, "rd_zero");
        drive(1'b0, 5'd5, 5'd0, 1'b0, CSR_NONE, RET_NONE, 1'b0, 5'd5, 1'b0, 5'b00000, "not_load");
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                // already driven; just align to each cycle's sample point
            end
        end
        repeat (0) @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            $display("FAIL %s: scoreboard entry left unchecked (want %b)", e.name, e.exp);
            bad++;
        end
    endtask

    task automatic test_csr();
        sb_t e;
        logic [4:0] exp_v [6] = '{5'b11100, 5'b11101, 5'b11101, 5'b11101, 5'b00001, 5'b00000};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 5'd1, 5'd2, 1'b0, (i < 5) ? CSR_RW : CSR_NONE, RET_NONE,
                  1'b0, 5'd0, 1'b0, exp_v[i], $sformatf("csr_cyc%0d", i));
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (obs() !== e.exp) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
            end
        end
    endtask

    task automatic test_mret();
        sb_t e;
        logic [4:0] exp_v [8] = '{5'b11100, 5'b11101, 5'b11101, 5'b11101,
                                  5'b00001, 5'b10011, 5'b10011, 5'b00000};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 5'd0, 5'd0, 1'b0, CSR_NONE, (i < 5) ? RET_MRET : RET_NONE,
                  1'b0, 5'd0, 1'b0, exp_v[i], $sformatf("mret_cyc%0d", i));
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (obs() !== e.exp) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
            end
        end
    endtask

    task automatic test_branch();
        sb_t e;
        logic [4:0] exp_v [5] = '{5'b11100, 5'b11101, 5'b10011, 5'b00000, 5'b10010};
        for (int i = 0; i < 5; i++) begin
            // Branch hits in 2nd DRAIN cycle; last cycle: branch + load-use together.
            drive(1'b0, 5'd4, 5'd0, 1'b0, (i < 3) ? CSR_RS : CSR_NONE, RET_NONE,
                  (i == 4), (i == 4) ? 5'd4 : 5'd0, (i == 2) || (i == 4),
                  exp_v[i], $sformatf("br_cyc%0d", i));
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (obs() !== e.exp) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
            end
        end
    endtask

    task automatic test_rst_flush();
        sb_t e;
        logic [4:0] exp_v [9] = '{5'b11100, 5'b11101, 5'b11101, 5'b11101,
                                  5'b00001, 5'b10011, 5'b10010, 5'b00000, 5'b00000};
        for (int i = 0; i < 9; i++) begin
            drive((i == 6), 5'd0, 5'd0, 1'b0, CSR_NONE, (i < 5) ? RET_SRET : RET_NONE,
                  1'b0, 5'd0, 1'b0, exp_v[i], $sformatf("rstfl_cyc%0d", i));
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (obs() !== e.exp) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
            end
            if (i == 7) begin
                total++;
                if (dut.cnt !== 2'd0 || dut.ret_q !== 1'b0) begin
                    bad++;
                    $display("FAIL rstfl_regs: cnt=%0d ret_q=%b want 0 0", dut.cnt, dut.ret_q);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        sb_t e;
        // CSR sequence followed directly by a load-use once the CSR issues.
        logic [4:0] exp_v [7] = '{5'b11100, 5'b11101, 5'b11101, 5'b11101,
                                  5'b00001, 5'b11100, 5'b00000};
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 5'd8, 5'd0, 1'b0, (i < 5) ? CSR_RW : CSR_NONE, RET_NONE,
                  (i == 5), (i == 5) ? 5'd8 : 5'd0, 1'b0, exp_v[i], $sformatf("b2b_cyc%0d", i));
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (obs() !== e.exp) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
            end
        end
    endtask

    task automatic test_load_use_cycles();
        sb_t e;
        logic [4:0] exp_v [6] = '{5'b11100, 5'b00000, 5'b11100, 5'b00000, 5'b00000, 5'b00000};
        logic       mr_v  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [4:0] rd_v  [6] = '{5'd5, 5'd0, 5'd9, 5'd7, 5'd0, 5'd5};
        logic [4:0] rs1_v [6] = '{5'd5, 5'd5, 5'd3, 5'd3, 5'd0, 5'd5};
        logic [4:0] rs2_v [6] = '{5'd0, 5'd0, 5'd9, 5'd7, 5'd7, 5'd0};
        logic       swf_v [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        string      nm_v  [6] = '{"lu_rs1", "lu_after", "lu_rs2", "store_rs2_fwd", "rd_zero", "not_load"};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, rs1_v[i], rs2_v[i], swf_v[i], CSR_NONE, RET_NONE,
                  mr_v[i], rd_v[i], 1'b0, exp_v[i], nm_v[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (obs() !== e.exp) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_mem_write_forward = 1'b0;
        id_csr_op = '0; id_priv_ret = '0; ex_mem_read = 1'b0; ex_rd = '0; ex_br_taken = 1'b0;
        test_reset();
        test_load_use_cycles();
        test_csr();
        test_mret();
        test_branch();
        test_rst_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
